// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op/state encodings and width helpers for the HI/LO unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int OP_W = 3;
    localparam int ST_W = 2;

    localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_CALC = 2'd1;
    localparam logic [ST_W-1:0] ST_FIX  = 2'd2;

    // Product accumulator and trial-subtract widths for a given operand width.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    function automatic int trial_width(input int w);
        return w + 1;
    endfunction

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter_core
// Description : One-bit-per-cycle shift-add multiply and restoring divide core.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  logic                         i_step,
    input  logic [WIDTH-1:0]             i_op_a,
    input  logic [WIDTH-1:0]             i_op_b,
    output logic [prod_width(WIDTH)-1:0] o_prod,
    output logic [WIDTH-1:0]             o_quo,
    output logic [WIDTH-1:0]             o_rem,
    output logic                         o_last
);

    localparam int PW = prod_width(WIDTH);
    localparam int TW = trial_width(WIDTH);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_divisor;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;

    logic [TW-1:0]    w_sum;
    logic [PW-1:0]    w_acc_nxt;
    logic [TW-1:0]    w_shift;
    logic [TW-1:0]    w_trial;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // Multiplier sits in the low half of the accumulator and is consumed LSB first.
    assign w_sum     = {1'b0, r_acc[PW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

    // A set MSB of the trial difference means the subtraction underflowed: restore.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_divisor};
    assign w_rem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand   <= '0;
            r_divisor <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
        end else if (i_load) begin
            r_mcand   <= i_op_a;
            r_divisor <= i_op_b;
            r_acc     <= {{WIDTH{1'b0}}, i_op_b};
            r_rem     <= '0;
            r_quo     <= i_op_a;
            r_cnt     <= CNT_W'(WIDTH);
        end else if (i_step) begin
            r_acc     <= w_acc_nxt;
            r_rem     <= w_rem_nxt;
            r_quo     <= w_quo_nxt;
            r_cnt     <= r_cnt - CNT_W'(1);
        end
    end

    assign o_prod = r_acc;
    assign o_quo  = r_quo;
    assign o_rem  = r_rem;
    assign o_last = (r_cnt == CNT_W'(1));

endmodule : muldiv_iter_core
`default_nettype wire

// File: rtl/muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_hilo_unit
// Description : Multi-cycle MULT/DIV unit owning HI/LO, with busy/done and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int PW    = prod_width(WIDTH);

    logic [ST_W-1:0]  r_state;
    logic             r_is_div;
    logic             r_neg;
    logic             r_sign_a;
    logic             r_div_zero;
    logic             r_done;
    logic [WIDTH-1:0] r_raw_a;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_go;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_signed;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_step;
    logic             w_commit;
    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic             w_last;
    logic [PW-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_hi_en;
    logic             w_lo_en;
    logic [WIDTH-1:0] w_hi_d;
    logic [WIDTH-1:0] w_lo_d;

    // A flush arriving with start in IDLE wins: nothing is launched.
    assign w_accept = (r_state == ST_IDLE) && start && !flush;
    assign w_go     = w_accept && is_muldiv(op);
    assign w_mthi   = w_accept && (op == OP_MTHI);
    assign w_mtlo   = w_accept && (op == OP_MTLO);
    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;
    assign w_step   = (r_state == ST_CALC);
    assign w_commit = (r_state == ST_FIX) && !flush;

    muldiv_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_go),
        .i_step (w_step),
        .i_op_a (w_a_mag),
        .i_op_b (w_b_mag),
        .o_prod (w_prod),
        .o_quo  (w_quo),
        .o_rem  (w_rem),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_is_div   <= 1'b0;
            r_neg      <= 1'b0;
            r_sign_a   <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
            r_raw_a    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_state    <= ST_CALC;
                        r_is_div   <= op[1];
                        r_neg      <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_sign_a   <= w_signed && a[WIDTH-1];
                        r_raw_a    <= a;
                        r_div_zero <= op[1] && (b == '0);
                    end else if (w_mthi || w_mtlo) begin
                        r_done     <= 1'b1;
                        r_div_zero <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_done  <= !flush;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Quotient follows the sign of the operand product, remainder the dividend.
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg ? -w_quo : w_quo;
    assign w_rem_fix  = r_sign_a ? -w_rem : w_rem;

    always_comb begin
        w_hi_en = 1'b0;
        w_lo_en = 1'b0;
        w_hi_d  = a;
        w_lo_d  = a;
        if (w_mthi) begin
            w_hi_en = 1'b1;
        end
        if (w_mtlo) begin
            w_lo_en = 1'b1;
        end
        if (w_commit) begin
            w_hi_en = 1'b1;
            w_lo_en = 1'b1;
            if (!r_is_div) begin
                w_hi_d = w_prod_fix[PW-1:WIDTH];
                w_lo_d = w_prod_fix[WIDTH-1:0];
            end else if (r_div_zero) begin
                w_hi_d = r_raw_a;
                w_lo_d = '1;
            end else begin
                w_hi_d = w_rem_fix;
                w_lo_d = w_quo_fix;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
        end else if (w_hi_en) begin
            r_hi <= w_hi_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lo <= '0;
        end else if (w_lo_en) begin
            r_lo <= w_lo_d;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule : muldiv_hilo_unit
`default_nettype wire

// File: tb/tb_muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_hilo_unit
// Description : Vector table, random model comparison and corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'd7;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        flush8 = 1'b0;
    logic        busy8, done8, div_zero8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_hilo_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    muldiv_hilo_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
        .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Plain-arithmetic reference for the four arithmetic ops.
    function automatic void model(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                                  output logic [31:0] eh, output logic [31:0] el, output logic edz);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa  = longint'($signed(va));
        sb  = longint'($signed(vb));
        ua  = {32'd0, va};
        ub  = {32'd0, vb};
        edz = 1'b0;
        eh  = '0;
        el  = '0;
        if (o == 3'd0) begin
            sq = sa * sb;
            {eh, el} = sq;
        end else if (o == 3'd1) begin
            up = ua * ub;
            {eh, el} = up;
        end else if (vb == 32'd0) begin
            edz = 1'b1;
            eh  = va;
            el  = '1;
        end else if (o == 3'd2) begin
            sq = sa / sb;
            sr = sa % sb;
            eh = sr[31:0];
            el = sq[31:0];
        end else begin
            up = ua % ub;
            eh = up[31:0];
            up = ua / ub;
            el = up[31:0];
        end
    endfunction

    // Launches one op on the 32-bit unit and waits (bounded) for done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          output int lat, output int busy_cnt, output logic dz1);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0; op = 3'd7;
        lat = 1; busy_cnt = 0; dz1 = div_zero;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb, output int lat);
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = va; b8 = vb;
        @(negedge clk);
        start8 = 1'b0; op8 = 3'd7;
        lat = 1;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat, bcnt, dcnt;
        logic        dz1, edz;
        logic [31:0] eh, el, ra, rb;
        logic [2:0]  ro;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, 1'b0, 34};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[3]  = '{3'd3, 32'd100,       32'h0,         32'd100,       32'hFFFF_FFFF, 1'b1, 34};
        vecs[4]  = '{3'd1, 32'd3,         32'd4,         32'h0,         32'd12,        1'b0, 34};
        vecs[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 34};
        vecs[6]  = '{3'd2, 32'h8000_0000, 32'h0,         32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34};
        vecs[7]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 1'b0, 34};
        vecs[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0, 34};
        vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999, 1'b0, 34};
        vecs[10] = '{3'd4, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h1999_9999, 1'b0, 1};
        vecs[11] = '{3'd5, 32'hA5A5_A5A5, 32'h0,         32'h1234_5678, 32'hA5A5_A5A5, 1'b0, 1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_dz", 64'(div_zero), 64'h0);
        check("rst_hi8", 64'({hi8, lo8}), 64'h0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, dz1);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i), 64'(bcnt), 64'(vecs[i].lat - 1));
            check($sformatf("vec%0d_dz1", i), 64'(dz1), 64'(vecs[i].dz));
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("vec%0d_dz", i), 64'(div_zero), 64'(vecs[i].dz));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'h0);
        end

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'h1;
                default: ;
            endcase
            model(ro, ra, rb, eh, el, edz);
            run_op(ro, ra, rb, lat, bcnt, dz1);
            check($sformatf("rnd%0d_lat op=%0d a=%h b=%h", i, ro, ra, rb), 64'(lat), 64'd34);
            check($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, ro, ra, rb), 64'(hi), 64'(eh));
            check($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, ro, ra, rb), 64'(lo), 64'(el));
            check($sformatf("rnd%0d_dz", i), 64'(div_zero), 64'(edz));
        end

        // Known HI/LO baseline for the abort sequences
        run_op(3'd4, 32'h1111_1111, 32'h0, lat, bcnt, dz1);
        run_op(3'd5, 32'h2222_2222, 32'h0, lat, bcnt, dz1);

        // Flush during CALC with a simultaneous re-start
        @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk); flush = 1'b1; start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd6;
        @(negedge clk); flush = 1'b0; start = 1'b0;
        check("flush_calc_busy", 64'(busy), 64'h0);
        dcnt = int'(done);
        repeat (40) begin @(negedge clk); if (done) dcnt++; end
        check("flush_calc_no_done", 64'(dcnt), 64'h0);
        check("flush_calc_hilo", {hi, lo}, 64'h1111_1111_2222_2222);

        // Flush during FIX (cycle WIDTH+1)
        @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
        @(negedge clk); start = 1'b0;
        repeat (32) @(negedge clk);
        check("fix_busy", 64'(busy), 64'h1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush_fix_busy", 64'(busy), 64'h0);
        dcnt = int'(done);
        repeat (5) begin @(negedge clk); if (done) dcnt++; end
        check("flush_fix_no_done", 64'(dcnt), 64'h0);
        check("flush_fix_hilo", {hi, lo}, 64'h1111_1111_2222_2222);

        // Flush with start in IDLE, and reserved op 6
        @(negedge clk); start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        check("idle_flush_done", 64'(done), 64'h0);
        check("idle_flush_hi", 64'(hi), 64'h1111_1111);
        @(negedge clk); start = 1'b1; op = 3'd6; a = 32'h5;
        @(negedge clk); start = 1'b0;
        check("nop_done_busy", 64'({done, busy}), 64'h0);
        check("nop_hilo", {hi, lo}, 64'h1111_1111_2222_2222);

        // Asynchronous reset mid-divide
        @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd2;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_hilo", {hi, lo}, 64'h0);
        check("midrst_flags", 64'({busy, done, div_zero}), 64'h0);
        @(negedge clk); rst = 1'b1;

        // Re-launch while busy is ignored
        @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd4; b = 32'd1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd7;
        @(negedge clk); start = 1'b0;
        lat = 6;
        while (!done && lat < 200) begin @(negedge clk); lat++; end
        check("relaunch_lat", 64'(lat), 64'd34);
        check("relaunch_hilo", {hi, lo}, 64'h0000_0000_0000_0004);
        dcnt = 0;
        repeat (40) begin @(negedge clk); if (done) dcnt++; end
        check("relaunch_no_queue", 64'(dcnt), 64'h0);

        // 8-bit instance
        run8(3'd0, 8'h80, 8'h80, lat);
        check("w8_mult_lat", 64'(lat), 64'd10);
        check("w8_mult_hilo", 64'({hi8, lo8}), 64'h4000);
        run8(3'd2, 8'h81, 8'h05, lat);
        check("w8_div_hilo", 64'({hi8, lo8}), 64'hFEE7);
        run8(3'd1, 8'hFF, 8'hFF, lat);
        check("w8_multu_hilo", 64'({hi8, lo8}), 64'hFE01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_muldiv_hilo_unit
`default_nettype wire

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Replaces the single-cycle combinational HI/LO path of the pipelined MIPS datapath.
- Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and MTHI/MTLO in a single cycle.
- Exposes a busy/done handshake so the hazard unit can stall MFHI/MFLO and back-to-back mul/div; supports pipeline flush (abort).

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  launch op; accepted only when busy=0.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, others=NOP.
- a  in  WIDTH  operand rs (multiplicand / dividend / MTHI-MTLO data).
- b  in  WIDTH  operand rt (multiplier / divisor).
- flush  in  1  abort an in-flight op; HI/LO unchanged.
- busy  out  1  op in progress.
- done  out  1  one-cycle pulse; new HI/LO visible this cycle.
- div_zero  out  1  sticky until next accepted start; last DIV/DIVU had b=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
- FSM states: IDLE, CALC, FIX.
- IDLE + start + op in {0..3}: latch |a| and |b| (signed ops) or raw a/b (unsigned ops), plus the sign bits and op. Counter=WIDTH. Go to CALC. busy=1 from the next cycle.
- IDLE + start + MTHI: hi<=a at that edge. MTLO: lo<=a at that edge. done=1 next cycle, busy stays 0.
- IDLE + start + op 6/7: ignored, no done.
- start while busy=1: ignored. No queuing; the hazard unit must stall.
- CALC: one iteration per cycle, counter decrements; at counter=1 the next state is FIX. CALC lasts exactly WIDTH cycles.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract with a WIDTH+1 partial remainder.
- FIX (1 cycle): sign correction, then commit at the FIX→IDLE edge.
  - Product is negated (2*WIDTH two's complement) when sign(a)≠sign(b) for MULT.
  - Quotient is negated when signs differ for DIV; remainder takes the sign of the dividend.
  - Commit: hi<=product[2W-1:W] or remainder; lo<=product[W-1:0] or quotient.
- Timing: start sampled at edge 0 → busy=1 during cycles 1..WIDTH+1 → done=1 and busy=0 in cycle WIDTH+2, with new hi/lo.
- done is high for exactly one cycle.
- Divide by zero (b=0 at accept): div_zero<=1 at the accept edge. Full latency still applies. Commit lo={WIDTH{1}}, hi=a (raw, no sign fix), for both DIV and DIVU.
- Overflow case DIV with a=most-negative and b=-1: lo=most-negative, hi=0 (natural two's complement wrap); no flag.
- flush=1 in CALC or FIX: next state IDLE, busy=0, no commit, no done. hi/lo/div_zero unchanged.
- flush in IDLE: no effect. flush and start together in IDLE: start is ignored.
- Reset asserted mid-operation: immediate return to the reset values; no partial commit.
- hi/lo change only on a commit edge, an MTHI/MTLO edge, or reset.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULT…OP_MTLO;
  - state encodings ST_IDLE/ST_CALC/ST_FIX;
  - localparam helpers for the abs/negate widths.
- One natural sub-module, muldiv_iter_core: the per-cycle shift-add / shift-subtract datapath (accumulator, partial remainder, counter), with an FSM wrapper around it.
- The HI/LO registers stay in the top module and reuse the existing enabled flop with async reset.

Test Plan:
- MULTU a=0xFFFFFFFF, b=2 → done at cycle 34: hi=0x00000001, lo=0xFFFFFFFE; busy high for cycles 1..33.
- MULT a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 → div_zero=1 at cycle 1; at done lo=0xFFFFFFFF, hi=100. A following MULTU 3*4 clears div_zero; lo=12, hi=0.
- Start MULTU 5*5, assert flush at cycle 10, then start=1 at cycle 10 → no done, hi/lo keep prior values, the second start is ignored. MTLO a=0xA5A5A5A5 → lo updated next edge, done one cycle, busy never high.
- Start DIVU 9/2, pulse rst=0 at cycle 15 → outputs zero immediately. After release, start=1 while busy (re-launch mid-op) is ignored, verified by an unchanged result 4/1.
- WIDTH=8 instance: MULT a=0x80, b=0x80 → hi=0x40, lo=0x00, done at cycle 10.
